// File: rtl/register_file.sv
// Register file with 2 combinational read ports and 1 synchronous write port.
// Register 0 is hardwired to zero. Optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] din,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            fwd_ok;

  // Write port: reset clears every entry and wins over a simultaneous write;
  // index 0 is never written so it always reads back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wen && (rd != '0)) begin
      regs[rd] <= din;
    end
  end

  // Forwarding is only legal for a real (non-x0) write outside reset.
  always_comb begin
    fwd_ok = (BYPASS != 0) && !rst && wen && (rd != '0);
  end

  // Read port 1: zero for x0, forwarded din on a matching write, else storage.
  always_comb begin
    r1 = regs[rs1];
    if (rs1 == '0) begin
      r1 = '0;
    end else if (fwd_ok && (rs1 == rd)) begin
      r1 = din;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    r2 = regs[rs2];
    if (rs2 == '0) begin
      r2 = '0;
    end else if (fwd_ok && (rs2 == rd)) begin
      r2 = din;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed and model-checked test of register_file with BYPASS enabled.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] din;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] r1;
  logic [31:0] r2;

  int unsigned errors;
  int unsigned checks;
  logic [31:0] mdl [32];
  logic [31:0] e1;
  logic [31:0] e2;

  register_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .wen (wen),
    .rd  (rd),
    .din (din),
    .rs1 (rs1),
    .rs2 (rs2),
    .r1  (r1),
    .r2  (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; wen = 1'b0; rd = '0; din = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // All indices read zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check("reset_r1", r1, 32'h0);
      check("reset_r2", r2, 32'h0);
    end

    // Bypass of x10 write before the edge; r1 on untouched x2.
    wen = 1'b1; rd = 5'd10; din = 32'hBABEFACE; rs1 = 5'd2; rs2 = 5'd10;
    #1;
    check("bypass_r2", r2, 32'hBABEFACE);
    check("bypass_r1", r1, 32'h0);
    tick();
    wen = 1'b0;
    #1;
    check("after_write_r2", r2, 32'hBABEFACE);
    check("after_write_r1", r1, 32'h0);

    // Write to x0 is ignored and never forwarded.
    wen = 1'b1; rd = 5'd0; din = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("x0_nobypass_r1", r1, 32'h0);
    check("x0_nobypass_r2", r2, 32'h0);
    tick();
    wen = 1'b0;
    #1;
    check("x0_after_r1", r1, 32'h0);

    // rd changes mid-cycle: only the value at the edge is written.
    wen = 1'b1; rd = 5'd10; din = 32'hBABEFACE;
    #2;
    rd = 5'd2;
    tick();
    wen = 1'b0; rs1 = 5'd2; rs2 = 5'd10;
    #1;
    check("midcycle_x2", r1, 32'hBABEFACE);
    check("midcycle_x10", r2, 32'hBABEFACE);
    wen = 1'b1; rd = 5'd7; din = 32'h11111111;
    #2;
    rd = 5'd3;
    tick();
    wen = 1'b0; rs1 = 5'd3; rs2 = 5'd7;
    #1;
    check("midcycle_x3", r1, 32'h11111111);
    check("midcycle_x7", r2, 32'h0);

    // Same register on both ports.
    rs1 = 5'd3; rs2 = 5'd3;
    #1;
    check("same_idx_r1", r1, 32'h11111111);
    check("same_idx_r2", r2, 32'h11111111);

    // Reset beats a simultaneous write; stored data visible, no bypass in reset.
    wen = 1'b1; rd = 5'd5; din = 32'h12345678; rst = 1'b1; rs1 = 5'd5; rs2 = 5'd10;
    #1;
    check("rst_nobypass_r1", r1, 32'h0);
    check("rst_stored_r2", r2, 32'hBABEFACE);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_bypass_r1", r1, 32'h12345678);
    check("post_rst_x10_r2", r2, 32'h0);
    tick();
    wen = 1'b0;
    #1;
    check("post_rst_write_r1", r1, 32'h12345678);

    // Overwrite forwarded before the edge, stored after.
    wen = 1'b1; rd = 5'd5; din = 32'hA5A5A5A5; rs1 = 5'd5; rs2 = 5'd5;
    #1;
    check("overwrite_bypass_r1", r1, 32'hA5A5A5A5);
    tick();
    wen = 1'b0; din = 32'h0;
    #1;
    check("overwrite_after_r2", r2, 32'hA5A5A5A5);

    // Unknown write enable must not modify storage.
    wen = 1'bx; rd = 5'd4; din = 32'hDEADBEEF;
    tick();
    wen = 1'b0; rs1 = 5'd4;
    #1;
    check("wen_x_r1", r1, 32'h0);

    // Randomised traffic against a reference array.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int n = 0; n < 1000; n++) begin
      wen = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      din = $urandom();
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      e1 = (rs1 == 5'd0) ? 32'h0 : ((wen && rd != 5'd0 && rs1 == rd) ? din : mdl[rs1]);
      e2 = (rs2 == 5'd0) ? 32'h0 : ((wen && rd != 5'd0 && rs2 == rd) ? din : mdl[rs2]);
      check("rand_r1", r1, e1);
      check("rand_r2", r2, e2);
      tick();
      if (wen && rd != 5'd0) mdl[rd] = din;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter XLEN SHALL default to 32 and set the register data width in bits.
REQ-003 Parameter NREGS SHALL default to 32 and set the number of architectural registers, with index 0 included.
REQ-004 Parameter AW SHALL default to 5 and set the register index width; NREGS SHALL equal 2**AW.
REQ-005 Parameter BYPASS SHALL default to 1 and select write-to-read forwarding: 1 = enabled, 0 = disabled.
REQ-006 Port clk SHALL be an input, 1 bit wide, and act as the clock for all state; all state updates on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit wide, and act as the synchronous active-high reset.
REQ-008 Port wen SHALL be an input, 1 bit wide, and act as the write enable.
REQ-009 Port rd SHALL be an input, AW bits wide, and carry the write (destination) register index.
REQ-010 Port din SHALL be an input, XLEN bits wide, and carry the write data.
REQ-011 Port rs1 SHALL be an input, AW bits wide, and carry the read port 1 register index.
REQ-012 Port rs2 SHALL be an input, AW bits wide, and carry the read port 2 register index.
REQ-013 Port r1 SHALL be an output, XLEN bits wide, and carry the read port 1 data.
REQ-014 Port r2 SHALL be an output, XLEN bits wide, and carry the read port 2 data.

Function
REQ-015 Storage SHALL be NREGS registers of XLEN bits each, with 2 read ports and 1 write port.
REQ-016 Register 0 SHALL be hardwired to zero: writes with rd=0 are ignored, and reads of index 0 return 0 in all cases.
REQ-017 Write: at a rising clk edge with rst=0, wen=1 and rd!=0, register[rd] SHALL take the value of din; with wen=0 no register changes.
REQ-018 Reads SHALL be combinational (zero latency): r1 = register[rs1] and r2 = register[rs2], updating within the same cycle as an address change.
REQ-019 Both read ports SHALL be independent and may address the same register, or the write register, at the same time.
REQ-020 With BYPASS=1 and wen=1, rd!=0 and rsN==rd, read port N SHALL return din in the same cycle, before the edge.
REQ-021 With BYPASS=0, read port N SHALL return the old register contents until the write edge and the new value after it.
REQ-022 A write SHALL be visible on the read ports with no wait in the cycle after the write edge, regardless of BYPASS.
REQ-023 When wen=1 and rd changes mid-cycle, only the rd value sampled at the edge SHALL determine which register is written.
REQ-024 When wen is X/Z at an edge, the register file SHALL remain unchanged. When a read index is X/Z, the corresponding output is don't-care and SHALL NOT corrupt state.
REQ-025 There SHALL be no handshake and no stall; a write may be issued every cycle.

Reset
REQ-026 At a rising clk edge with rst=1, all registers SHALL be cleared to 0.
REQ-027 rst SHALL have priority over a simultaneous write; the write is discarded.
REQ-028 During reset, the read ports SHALL show the stored contents combinationally; bypass is suppressed while rst=1. After the reset edge, r1=r2=0 for every index.
REQ-029 Reset asserted mid-operation SHALL take effect only at the next rising edge; register contents before that edge remain readable.

Verification
REQ-030 Reset, then read all indices on both ports -> r1=r2=32'h00000000 for every index.
REQ-031 wen=1, rd=10, din=32'hBABEFACE, rs1=2, rs2=10, checked before the edge -> with BYPASS=1, r2=32'hBABEFACE and r1=0; after the edge with wen=0 -> r2=32'hBABEFACE.
REQ-032 wen=1, rd=0, din=32'hFFFFFFFF, edge; then rs1=0 -> r1=0; bypass is also not applied for index 0.
REQ-033 Write 32'hBABEFACE to x10, then change rd to 2 with wen=1 and din unchanged, edge -> x2=x10=32'hBABEFACE; rs1=2 and rs2=10 read both values simultaneously.
REQ-034 wen=1, rd=5, din=32'h12345678, rst=1 at the same edge -> x5=0 after the edge; the next edge with rst=0 writes 32'h12345678.
REQ-035 Randomized writes and reads (≥1000 cycles) against a reference array model -> r1 and r2 match every cycle, including same-index and write-forwarding cases.
